// File: rtl/io_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp,
// CPU I/O bus register interface and a registered mtimecmp <= mtime flag.
module io_timer #(
   parameter logic [15:2] TBASE = 14'h3F00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dma_io_we,
   input  logic [15:2] dma_io_wadr,
   input  logic [31:0] dma_io_wdata,
   input  logic [15:2] dma_io_radr,
   input  logic        dma_io_radr_en,
   output logic [31:0] dma_io_rdata_in,
   output logic        frc_cntr_val_leq
);

   typedef enum logic [2:0] {
      REG_MTIME_LO = 3'd0,
      REG_MTIME_HI = 3'd1,
      REG_CMP_LO   = 3'd2,
      REG_CMP_HI   = 3'd3,
      REG_CTRL     = 3'd4,
      REG_PRESCALE = 3'd5
   } reg_e;

   logic [63:0] mtime;
   logic [63:0] mtime_inc;
   logic [63:0] mtime_nx;
   logic [63:0] mtimecmp;
   logic [31:0] hi_shadow;
   logic [15:0] pcnt;
   logic [15:0] prescale;
   logic        en;
   logic        tick;

   logic [15:2] w_off;
   logic [15:2] r_off;
   logic        w_hit;
   logic        r_hit;
   logic        wr_lo;
   logic        wr_hi;
   logic        wr_cmp_lo;
   logic        wr_cmp_hi;
   logic        wr_ctrl;
   logic        wr_pre;
   logic        clr;
   logic        rd_lo;
   logic [31:0] rd_mux;

   // Offsets are computed modulo 2^14, so addresses below TBASE wrap high and miss.
   assign w_off = dma_io_wadr - TBASE;
   assign r_off = dma_io_radr - TBASE;
   assign w_hit = dma_io_we && (w_off < 14'd6);
   assign r_hit = dma_io_radr_en && (r_off < 14'd6);

   always_comb begin
      wr_lo     = 1'b0;
      wr_hi     = 1'b0;
      wr_cmp_lo = 1'b0;
      wr_cmp_hi = 1'b0;
      wr_ctrl   = 1'b0;
      wr_pre    = 1'b0;
      if (w_hit) begin
         case (w_off[4:2])
            REG_MTIME_LO: wr_lo     = 1'b1;
            REG_MTIME_HI: wr_hi     = 1'b1;
            REG_CMP_LO:   wr_cmp_lo = 1'b1;
            REG_CMP_HI:   wr_cmp_hi = 1'b1;
            REG_CTRL:     wr_ctrl   = 1'b1;
            REG_PRESCALE: wr_pre    = 1'b1;
            default:      ;
         endcase
      end
   end

   assign clr   = wr_ctrl && dma_io_wdata[1];
   assign rd_lo = r_hit && (r_off[4:2] == REG_MTIME_LO);
   assign tick  = en && (pcnt == prescale);

   // A half write suppresses the carry of a same-cycle tick into the other half.
   always_comb begin
      mtime_inc = mtime + 64'(tick);
      mtime_nx  = mtime_inc;
      if (clr)
         mtime_nx = '0;
      else if (wr_lo)
         mtime_nx = {mtime[63:32], dma_io_wdata};
      else if (wr_hi)
         mtime_nx = {dma_io_wdata, mtime_inc[31:0]};
   end

   always_comb begin
      rd_mux = '0;
      case (r_off[4:2])
         REG_MTIME_LO: rd_mux = mtime[31:0];
         REG_MTIME_HI: rd_mux = hi_shadow;
         REG_CMP_LO:   rd_mux = mtimecmp[31:0];
         REG_CMP_HI:   rd_mux = mtimecmp[63:32];
         REG_CTRL:     rd_mux = {31'd0, en};
         REG_PRESCALE: rd_mux = {16'd0, prescale};
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime    <= '0;
         pcnt     <= '0;
         mtimecmp <= '1;
         en       <= 1'b0;
         prescale <= '0;
      end else begin
         mtime <= mtime_nx;
         if (clr || wr_pre)
            pcnt <= '0;
         else if (en)
            pcnt <= tick ? '0 : pcnt + 16'd1;
         if (wr_cmp_lo)
            mtimecmp[31:0] <= dma_io_wdata;
         if (wr_cmp_hi)
            mtimecmp[63:32] <= dma_io_wdata;
         if (wr_ctrl)
            en <= dma_io_wdata[0];
         if (wr_pre)
            prescale <= dma_io_wdata[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_shadow        <= '0;
         dma_io_rdata_in  <= '0;
         frc_cntr_val_leq <= 1'b0;
      end else begin
         if (rd_lo)
            hi_shadow <= mtime[63:32];
         dma_io_rdata_in  <= r_hit ? rd_mux : '0;
         frc_cntr_val_leq <= (mtimecmp <= mtime);
      end
   end

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: a per-cycle vector table for register access
// and decode, plus hand-written sequences for counting, carry and collisions.
module tb_io_timer;

   localparam logic [15:2] TB = 14'h3F00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dma_io_we;
   logic [15:2] dma_io_wadr;
   logic [31:0] dma_io_wdata;
   logic [15:2] dma_io_radr;
   logic        dma_io_radr_en;
   logic [31:0] dma_io_rdata_in;
   logic        frc_cntr_val_leq;

   int n_vec = 0;
   int n_err = 0;

   io_timer #(.TBASE(TB)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .dma_io_we        (dma_io_we),
      .dma_io_wadr      (dma_io_wadr),
      .dma_io_wdata     (dma_io_wdata),
      .dma_io_radr      (dma_io_radr),
      .dma_io_radr_en   (dma_io_radr_en),
      .dma_io_rdata_in  (dma_io_rdata_in),
      .frc_cntr_val_leq (frc_cntr_val_leq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      int          woff;
      logic [31:0] wd;
      bit          re;
      int          roff;
      logic [31:0] exp_rd;
      bit          exp_flag;
   } vec_t;

   vec_t tbl[36];

   function automatic vec_t mk(bit we, int woff, logic [31:0] wd, bit re, int roff,
                               logic [31:0] exp_rd, bit exp_flag);
      vec_t v;
      v.we = we; v.woff = woff; v.wd = wd; v.re = re; v.roff = roff;
      v.exp_rd = exp_rd; v.exp_flag = exp_flag;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One bus cycle: inputs set at a negedge, held across one posedge.
   task automatic cyc(input bit we, input int woff, input logic [31:0] wd,
                      input bit re, input int roff);
      dma_io_we      = we;
      dma_io_wadr    = TB + 14'(woff);
      dma_io_wdata   = wd;
      dma_io_radr_en = re;
      dma_io_radr    = TB + 14'(roff);
      @(negedge clk);
      dma_io_we      = 1'b0;
      dma_io_radr_en = 1'b0;
   endtask

   task automatic wr(input int off, input logic [31:0] d);
      cyc(1'b1, off, d, 1'b0, 0);
   endtask

   task automatic idle();
      cyc(1'b0, 0, '0, 1'b0, 0);
   endtask

   task automatic rd_chk(input string nm, input int off, input logic [31:0] exp);
      cyc(1'b0, 0, '0, 1'b1, off);
      chk(nm, dma_io_rdata_in, exp);
   endtask

   task automatic flag_chk(input string nm, input bit exp);
      chk(nm, {31'd0, frc_cntr_val_leq}, {31'd0, exp});
   endtask

   initial begin
      logic [31:0] seq_b1[9];
      logic [31:0] seq_b2[5];
      bit          seq_d[4];

      //              we woff wd             re roff exp_rd        flag
      tbl[0]  = mk(0,  0, 32'h0,          0,  0, 32'h0,          0);
      tbl[1]  = mk(0,  0, 32'h0,          1,  4, 32'h0,          0);
      tbl[2]  = mk(0,  0, 32'h0,          1,  2, 32'hFFFF_FFFF,  0);
      tbl[3]  = mk(0,  0, 32'h0,          1,  3, 32'hFFFF_FFFF,  0);
      tbl[4]  = mk(0,  0, 32'h0,          1,  5, 32'h0,          0);
      tbl[5]  = mk(1,  0, 32'h10,         0,  0, 32'h0,          0);
      tbl[6]  = mk(1,  2, 32'h10,         1,  0, 32'h10,         0);
      tbl[7]  = mk(1,  3, 32'h0,          1,  2, 32'h10,         0);
      tbl[8]  = mk(0,  0, 32'h0,          0,  0, 32'h0,          1);
      tbl[9]  = mk(1,  2, 32'd100,        1,  2, 32'h10,         1);
      tbl[10] = mk(0,  0, 32'h0,          0,  0, 32'h0,          0);
      tbl[11] = mk(1,  1, 32'h5,          1,  1, 32'h0,          0);
      tbl[12] = mk(0,  0, 32'h0,          1,  1, 32'h0,          1);
      tbl[13] = mk(0,  0, 32'h0,          1,  0, 32'h10,         1);
      tbl[14] = mk(0,  0, 32'h0,          1,  1, 32'h5,          1);
      tbl[15] = mk(0,  0, 32'h0,          1,  6, 32'h0,          1);
      tbl[16] = mk(0,  0, 32'h0,          1, -1, 32'h0,          1);
      tbl[17] = mk(1,  6, 32'hDEAD,       0,  0, 32'h0,          1);
      tbl[18] = mk(1, -1, 32'hBEEF,       0,  0, 32'h0,          1);
      tbl[19] = mk(0,  0, 32'h0,          1,  0, 32'h10,         1);
      tbl[20] = mk(0,  0, 32'h0,          1,  1, 32'h5,          1);
      tbl[21] = mk(0,  0, 32'h0,          1,  2, 32'd100,        1);
      tbl[22] = mk(0,  0, 32'h0,          1,  3, 32'h0,          1);
      tbl[23] = mk(0,  0, 32'h0,          1,  4, 32'h0,          1);
      tbl[24] = mk(0,  0, 32'h0,          1,  5, 32'h0,          1);
      tbl[25] = mk(1,  5, 32'hABCD_1234,  0,  0, 32'h0,          1);
      tbl[26] = mk(0,  0, 32'h0,          1,  5, 32'h1234,       1);
      tbl[27] = mk(1,  4, 32'hFFFF_FFFC,  0,  0, 32'h0,          1);
      tbl[28] = mk(0,  0, 32'h0,          1,  4, 32'h0,          1);
      tbl[29] = mk(1,  4, 32'h2,          0,  0, 32'h0,          1);
      tbl[30] = mk(0,  0, 32'h0,          1,  0, 32'h0,          0);
      tbl[31] = mk(0,  0, 32'h0,          1,  1, 32'h0,          0);
      tbl[32] = mk(1,  4, 32'h3,          0,  0, 32'h0,          0);
      tbl[33] = mk(0,  0, 32'h0,          1,  4, 32'h1,          0);
      tbl[34] = mk(1,  4, 32'h0,          0,  0, 32'h0,          0);
      tbl[35] = mk(0,  0, 32'h0,          1,  4, 32'h0,          0);

      seq_b1 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
      seq_b2 = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd3};
      seq_d  = '{1'b0, 1'b0, 1'b1, 1'b1};

      rst_n = 1'b0;
      dma_io_we = 1'b0; dma_io_wadr = '0; dma_io_wdata = '0;
      dma_io_radr = '0; dma_io_radr_en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         cyc(tbl[i].we, tbl[i].woff, tbl[i].wd, tbl[i].re, tbl[i].roff);
         chk($sformatf("vec%0d rdata", i), dma_io_rdata_in, tbl[i].exp_rd);
         flag_chk($sformatf("vec%0d flag", i), tbl[i].exp_flag);
      end

      // Enable with PRESCALE=0: one increment per cycle.
      wr(5, 32'h0); wr(0, 32'h0); wr(1, 32'h0); wr(4, 32'h1);
      idle();
      for (int unsigned k = 1; k <= 3; k++)
         rd_chk($sformatf("count%0d", k), 0, 32'(k));
      flag_chk("count flag", 1'b0);
      wr(4, 32'h0);

      // PRESCALE=3: one increment per 4 cycles; rewriting restarts the phase.
      wr(4, 32'h2); wr(5, 32'h3); wr(4, 32'h1);
      for (int unsigned k = 0; k < 9; k++)
         rd_chk($sformatf("presc%0d", k), 0, seq_b1[k]);
      wr(5, 32'h3);
      for (int unsigned k = 0; k < 5; k++)
         rd_chk($sformatf("rephase%0d", k), 0, seq_b2[k]);
      wr(4, 32'h0);

      // Atomic LO/HI sample across a carry.
      wr(5, 32'h0); wr(0, 32'hFFFF_FFFE); wr(1, 32'h0); wr(4, 32'h1);
      idle();
      rd_chk("atomic lo", 0, 32'hFFFF_FFFF);
      rd_chk("atomic hi", 1, 32'h0);
      wr(4, 32'h0);
      wr(0, 32'hFFFF_FFFE); wr(1, 32'h0); wr(4, 32'h1);
      idle();
      wr(4, 32'h0);
      rd_chk("carry lo", 0, 32'h0);
      rd_chk("carry hi", 1, 32'h1);
      flag_chk("carry flag", 1'b1);

      // Compare flag rise and fall.
      wr(0, 32'd10); wr(1, 32'h0); wr(3, 32'h0); wr(2, 32'd12); wr(4, 32'h1);
      flag_chk("cmp flag e0", 1'b0);
      for (int unsigned k = 0; k < 4; k++) begin
         idle();
         flag_chk($sformatf("cmp flag e%0d", k + 1), seq_d[k]);
      end
      wr(2, 32'd100);
      flag_chk("cmp drop +1", 1'b1);
      idle();
      flag_chk("cmp drop +2", 1'b0);
      wr(4, 32'h0);

      // LO write colliding with a carrying tick, then CLR while counting.
      wr(0, 32'hFFFF_FFFF); wr(1, 32'h7); wr(4, 32'h1);
      wr(0, 32'hAAAA_5555);
      rd_chk("collide lo", 0, 32'hAAAA_5555);
      rd_chk("collide hi", 1, 32'h7);
      wr(4, 32'h3);
      rd_chk("clr run", 0, 32'h0);
      wr(4, 32'h0);

      // Asynchronous reset mid-count with a live read and a high flag.
      wr(2, 32'h0); wr(4, 32'h1);
      idle(); idle();
      cyc(1'b0, 0, '0, 1'b1, 4);
      chk("pre-reset rdata", dma_io_rdata_in, 32'h1);
      flag_chk("pre-reset flag", 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rdata", dma_io_rdata_in, 32'h0);
      flag_chk("async flag", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_chk("post-reset cmp lo", 2, 32'hFFFF_FFFF);
      rd_chk("post-reset mtime", 0, 32'h0);
      rd_chk("post-reset ctrl", 4, 32'h0);
      rd_chk("post-reset mtime2", 0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/io_timer.md
# io_timer

Memory-mapped machine timer on the CPU I/O bus. It holds a 64-bit free-running counter (mtime) with a programmable prescaler and a 64-bit compare register (mtimecmp). It answers CPU I/O reads and writes issued through `dma_io_*`. It drives `frc_cntr_val_leq` back into `cpu_top`, which combines that flag with `csr_mtie` to raise the machine timer interrupt.

## Interface
Parameters:
- `TBASE`, default 14'h3F00: word address (bits [15:2]) of register 0; the block decodes TBASE..TBASE+5.

Ports (name, direction, width, meaning):
- `clk`  in  1  — the single clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `dma_io_we`  in  1  — write strobe, single cycle.
- `dma_io_wadr`  in  [15:2]  — write word address.
- `dma_io_wdata`  in  [31:0]  — write data.
- `dma_io_radr`  in  [15:2]  — read word address.
- `dma_io_radr_en`  in  1  — read strobe, single cycle.
- `dma_io_rdata_in`  out  [31:0]  — read data; 0 when no hit, so it can be OR-ed with other I/O slaves.
- `frc_cntr_val_leq`  out  1  — registered flag for mtimecmp <= mtime.

## Operation
Register map (word offset from TBASE):
- +0 MTIME_LO: RW.
- +1 MTIME_HI: RW; a read returns the shadow value.
- +2 MTIMECMP_LO: RW.
- +3 MTIMECMP_HI: RW.
- +4 CTRL: bit0 EN (RW); bit1 CLR (write-1 pulse, reads 0); bits [31:2] read 0.
- +5 PRESCALE: bits [15:0] RW; bits [31:16] read 0.

Prescaler and counting:
- A 16-bit prescale counter `pcnt` runs only while EN=1.
- When `pcnt == PRESCALE`, the block asserts `tick` and `pcnt` returns to 0; otherwise `pcnt` increments.
- PRESCALE=0 gives a tick every cycle.
- Each tick increments mtime by 1 as a full 64-bit add; mtime wraps from 2^64-1 to 0.
- While EN=0, `pcnt` and mtime hold.

Writes (take effect at the edge where `dma_io_we` is high and the address hits):
- Writing MTIME_LO or MTIME_HI replaces that half only. A write in the same cycle as a tick wins: the written half takes the written value, and no carry from that tick reaches the other half.
- Writing CLR=1 zeroes mtime and `pcnt`. CLR has priority over a same-cycle tick. The EN bit is written from the same data word.
- Writing PRESCALE zeroes `pcnt`.
- Writes to unmapped addresses, and to offsets 6 and above, are ignored.

Reads:
- Reading MTIME_LO returns the live mtime[31:0] and, at the same edge, copies mtime[63:32] into `hi_shadow`.
- Reading MTIME_HI returns `hi_shadow`. A LO-then-HI read pair is therefore an atomic 64-bit sample.
- All other registers return their live value.

Compare:
- `frc_cntr_val_leq` <= (mtimecmp <= mtime), an unsigned 64-bit compare, evaluated every cycle regardless of EN.

## Timing
Reset values:
- mtime = 0, `pcnt` = 0, `hi_shadow` = 0.
- mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, so the flag stays low after reset.
- EN = 0, PRESCALE = 0.
- `dma_io_rdata_in` = 0, `frc_cntr_val_leq` = 0.

Read latency:
- `radr_en` asserted in cycle N → data appears on `dma_io_rdata_in` in cycle N+1, for exactly one cycle.
- In every other cycle the output is 0, including cycles where the read address misses.

Write latency:
- `we` in cycle N → register updated at the end of cycle N, visible to a read issued in cycle N+1.

Flag latency:
- Flag = compare of the register values at cycle N, visible in cycle N+1. A write to mtimecmp therefore changes the flag two cycles after `we`.

Concurrency and reset:
- A read and a write in the same cycle to the same register: the read returns the old value.
- Asynchronous reset mid-count returns all state to the reset values immediately; there is no pending-operation state to flush.

## Test plan
- **Reset, then enable:** write CTRL=1 with PRESCALE=0 → mtime reads 1 on the first tick after the write and increments by 1 per cycle; flag stays 0.
- **Prescale:** write PRESCALE=3, CTRL=1 → mtime increments once every 4 cycles; writing PRESCALE again restarts the 4-cycle phase.
- **Carry and atomic read:** write MTIME_LO=FFFF_FFFE, MTIME_HI=0, enable → after 2 ticks, LO reads 0000_0000 and HI reads 0000_0001. A LO read taken at FFFF_FFFF followed by a HI read after the carry still returns 0.
- **Compare:** mtime=10, write mtimecmp=12 (HI=0 then LO=12) → flag rises one cycle after mtime reaches 12. Writing mtimecmp=100 drops the flag two cycles after the write.
- **Collision:** a MTIME_LO write in the same cycle as a tick → the written value is stored with no increment. A CLR write during counting → mtime=0 the next cycle.
- **Address decode:** a read at TBASE+6 and a read at TBASE-1 → `dma_io_rdata_in` is 0. A write at TBASE+6 changes no register.
